// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the UART receiver/consumer side and uart_rx_ctrl.
// The DUT uses the slave modport; the environment uses the master modport.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH) + 1;

    logic          i_Rx_DV;
    logic [7:0]    i_Rx_Byte;
    logic          o_Rx_Next;
    logic          i_Rd_En;
    logic [7:0]    o_Rd_Data;
    logic          o_Empty;
    logic          o_Full;
    logic [AW-1:0] o_Count;
    logic [AW-1:0] o_Line_Cnt;
    logic          o_Line_Ready;
    logic          o_Overflow;
    logic          i_Clr_Overflow;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Rd_En, i_Clr_Overflow,
        input  o_Rx_Next, o_Rd_Data, o_Empty, o_Full, o_Count,
               o_Line_Cnt, o_Line_Ready, o_Overflow
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Rd_En, i_Clr_Overflow,
        output o_Rx_Next, o_Rd_Data, o_Empty, o_Full, o_Count,
               o_Line_Cnt, o_Line_Ready, o_Overflow
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: captures one byte per receiver valid pulse into a
// first-word-fall-through FIFO, tracks buffered line terminators and overflow.
module uart_rx_ctrl #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] LINE_CHAR = 8'h0D
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    uart_rx_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_WRITE, S_ACK} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] count, line_cnt;
    logic          ovf, rx_next;
    logic [7:0]    mem [DEPTH];

    logic       empty, full, pop, push, drop, line_in, line_out;
    logic [7:0] head;

    assign empty    = (count == '0);
    assign full     = (count == AW'(DEPTH));
    assign head     = mem[rd_ptr];
    assign pop      = bus.i_Rd_En && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push     = (state == S_WRITE) && (!full || pop);
    assign drop     = (state == S_WRITE) && !push;
    assign line_in  = push && (bus.i_Rx_Byte == LINE_CHAR);
    assign line_out = pop && (head == LINE_CHAR);

    always_comb begin
        state_nx = state;
        case (state)
            S_FLUSH: if (!bus.i_Rx_DV) state_nx = S_IDLE;
            S_IDLE:  if (bus.i_Rx_DV)  state_nx = S_WRITE;
            S_WRITE: state_nx = S_ACK;
            S_ACK:   if (!bus.i_Rx_DV) state_nx = S_IDLE;
            default: state_nx = S_FLUSH;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= S_FLUSH;
            rx_next  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            line_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state   <= state_nx;
            // Release the receiver whenever we wait for DV to drop.
            rx_next <= (state_nx == S_FLUSH) || (state_nx == S_ACK);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({line_in, line_out})
                2'b10:   line_cnt <= line_cnt + 1'b1;
                2'b01:   line_cnt <= line_cnt - 1'b1;
                default: line_cnt <= line_cnt;
            endcase
            if (drop)                    ovf <= 1'b1;
            else if (bus.i_Clr_Overflow) ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push && !i_Reset) mem[wr_ptr] <= bus.i_Rx_Byte;
    end

    assign bus.o_Rx_Next    = rx_next;
    assign bus.o_Rd_Data    = empty ? 8'h00 : head;
    assign bus.o_Empty      = empty;
    assign bus.o_Full       = full;
    assign bus.o_Count      = count;
    assign bus.o_Line_Cnt   = line_cnt;
    assign bus.o_Line_Ready = (line_cnt != '0);
    assign bus.o_Overflow   = ovf;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: accepted bytes are queued as they are sent
// and compared against the FIFO head as they are popped.
module tb_uart_rx_ctrl;
    localparam int         DEPTH = 16;
    localparam logic [7:0] LC    = 8'h0D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(.DEPTH(DEPTH), .LINE_CHAR(LC)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [$];
    int         m_count = 0;
    int         m_line  = 0;
    bit         m_ovf   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(bus.o_Count), m_count);
        chk({tag, ".empty"}, 32'(bus.o_Empty), 32'(m_count == 0));
        chk({tag, ".full"}, 32'(bus.o_Full), 32'(m_count == DEPTH));
        chk({tag, ".line"}, 32'(bus.o_Line_Cnt), m_line);
        chk({tag, ".lrdy"}, 32'(bus.o_Line_Ready), 32'(m_line != 0));
        chk({tag, ".ovf"}, 32'(bus.o_Overflow), 32'(m_ovf));
        chk({tag, ".head"}, 32'(bus.o_Rd_Data), (sb.size() > 0) ? 32'(sb[0]) : 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_count = 0;
        m_line  = 0;
        m_ovf   = 1'b0;
    endtask

    // DV high for 'hold' cycles; optional pop / overflow clear in the write cycle.
    task automatic send(input logic [7:0] b, input int hold, input bit rd_w, input bit clr_w);
        bit         had, popd, acc;
        logic [7:0] pv;
        had  = (sb.size() > 0);
        popd = rd_w && had;
        pv   = had ? sb[0] : 8'h00;
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        tick();
        if (rd_w) begin
            bus.i_Rd_En = 1'b1;
            chk("rd_in_write", 32'(bus.o_Rd_Data), 32'(pv));
        end
        bus.i_Clr_Overflow = clr_w;
        acc = (m_count < DEPTH) || popd;
        tick();
        bus.i_Rd_En        = 1'b0;
        bus.i_Clr_Overflow = 1'b0;
        if (popd) begin
            void'(sb.pop_front());
            m_count--;
            if (pv == LC) m_line--;
        end
        if (acc) begin
            sb.push_back(b);
            m_count++;
            if (b == LC) m_line++;
            if (clr_w) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
        check_state("after_write");
        chk("rxnext_ack", 32'(bus.o_Rx_Next), 32'h1);
        for (int i = 2; i < hold; i++) tick();
        if (hold > 2) begin
            chk("single_push", 32'(bus.o_Count), m_count);
            chk("rxnext_hold", 32'(bus.o_Rx_Next), 32'h1);
        end
        bus.i_Rx_DV = 1'b0;
        tick();
        chk("rxnext_idle", 32'(bus.o_Rx_Next), 32'h0);
    endtask

    task automatic pop();
        bit had;
        had = (sb.size() > 0);
        bus.i_Rd_En = 1'b1;
        chk("pop_data", 32'(bus.o_Rd_Data), had ? 32'(sb[0]) : 32'h0);
        tick();
        bus.i_Rd_En = 1'b0;
        if (had) begin
            if (sb[0] == LC) m_line--;
            void'(sb.pop_front());
            m_count--;
        end
        check_state("after_pop");
    endtask

    initial begin
        bus.i_Rx_DV        = 1'b0;
        bus.i_Rx_Byte      = 8'h00;
        bus.i_Rd_En        = 1'b0;
        bus.i_Clr_Overflow = 1'b0;
        #2;

        // Reset: one flush cycle, then idle.
        do_reset();
        chk("rst_rxnext", 32'(bus.o_Rx_Next), 32'h1);
        check_state("rst");
        tick();
        chk("flush_done_rxnext", 32'(bus.o_Rx_Next), 32'h0);
        check_state("idle");

        // Long DV: single capture.
        send(8'h41, 40, 1'b0, 1'b0);
        chk("long_head", 32'(bus.o_Rd_Data), 32'h41);
        pop();
        pop();

        // Fill, then overflow.
        for (int i = 0; i < DEPTH; i++) send(8'(i), 3, 1'b0, 1'b0);
        send(8'h55, 3, 1'b0, 1'b0);
        chk("ovf_head", 32'(bus.o_Rd_Data), 32'h00);
        chk("ovf_flag", 32'(bus.o_Overflow), 32'h1);
        bus.i_Clr_Overflow = 1'b1;
        tick();
        bus.i_Clr_Overflow = 1'b0;
        m_ovf = 1'b0;
        check_state("clr");

        // Drop coinciding with clear: set wins.
        send(8'h66, 2, 1'b0, 1'b1);
        chk("set_wins", 32'(bus.o_Overflow), 32'h1);
        bus.i_Clr_Overflow = 1'b1;
        tick();
        bus.i_Clr_Overflow = 1'b0;
        m_ovf = 1'b0;
        check_state("clr2");

        // Full with pop in the write cycle: accepted, count stays full.
        send(8'hAA, 2, 1'b1, 1'b0);
        chk("full_swap_ovf", 32'(bus.o_Overflow), 32'h0);
        while (sb.size() > 0) pop();
        chk("drain_empty", 32'(bus.o_Empty), 32'h1);

        // Line terminator tracking.
        send(8'h48, 2, 1'b0, 1'b0);
        send(8'h69, 2, 1'b0, 1'b0);
        send(LC, 2, 1'b0, 1'b0);
        chk("line_cnt", 32'(bus.o_Line_Cnt), 32'h1);
        chk("line_rdy", 32'(bus.o_Line_Ready), 32'h1);
        pop();
        pop();
        pop();
        chk("line_clear", 32'(bus.o_Line_Cnt), 32'h0);
        chk("line_empty_data", 32'(bus.o_Rd_Data), 32'h0);

        // Random mix, exercising wrap and simultaneous push/pop.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) pop();
            else send(($urandom_range(0, 2) == 0) ? LC : 8'($urandom),
                      int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)), 1'b0);
        end
        while (sb.size() > 0) pop();

        // Reset in ACK with DV still high: stale byte must not be captured.
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = 8'h77;
        tick();
        tick();
        chk("pre_rst_count", 32'(bus.o_Count), 32'h1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("rst_ack_rxnext", 32'(bus.o_Rx_Next), 32'h1);
            chk("rst_ack_count", 32'(bus.o_Count), 32'h0);
            tick();
        end
        bus.i_Rx_DV = 1'b0;
        tick();
        chk("rst_ack_idle", 32'(bus.o_Rx_Next), 32'h0);
        tick();
        tick();
        check_state("rst_ack_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
